// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared encodings for the MIPS execute stage.
//   - aluop (8 bit) and alusel (3 bit) codes decoded in ID
//   - FSM state type for the iterative multiply/divide unit
//   - small decode helpers shared by the top and the iterative unit
package ex_muldiv_pkg;

    localparam int unsigned OP_W      = 8;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned W_DEFAULT = 32;

    // Operation codes
    localparam logic [OP_W-1:0] OP_NOP   = 8'b0000_0000;
    localparam logic [OP_W-1:0] OP_SRL   = 8'b0000_0010;
    localparam logic [OP_W-1:0] OP_SRA   = 8'b0000_0011;
    localparam logic [OP_W-1:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [OP_W-1:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [OP_W-1:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [OP_W-1:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [OP_W-1:0] OP_MULT  = 8'b0001_1000;
    localparam logic [OP_W-1:0] OP_MULTU = 8'b0001_1001;
    localparam logic [OP_W-1:0] OP_DIV   = 8'b0001_1010;
    localparam logic [OP_W-1:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [OP_W-1:0] OP_ADD   = 8'b0010_0000;
    localparam logic [OP_W-1:0] OP_SUB   = 8'b0010_0010;
    localparam logic [OP_W-1:0] OP_AND   = 8'b0010_0100;
    localparam logic [OP_W-1:0] OP_OR    = 8'b0010_0101;
    localparam logic [OP_W-1:0] OP_XOR   = 8'b0010_0110;
    localparam logic [OP_W-1:0] OP_NOR   = 8'b0010_0111;
    localparam logic [OP_W-1:0] OP_SLT   = 8'b0010_1010;
    localparam logic [OP_W-1:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [OP_W-1:0] OP_SLL   = 8'b0111_1100;

    // Result classes
    localparam logic [SEL_W-1:0] SEL_NOP   = 3'b000;
    localparam logic [SEL_W-1:0] SEL_LOGIC = 3'b001;
    localparam logic [SEL_W-1:0] SEL_SHIFT = 3'b010;
    localparam logic [SEL_W-1:0] SEL_MOVE  = 3'b011;
    localparam logic [SEL_W-1:0] SEL_ARITH = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: ID/EX inputs and EX/MEM outputs of the execute stage.
//   master: pipeline side (drives *_i, receives *_o)
//   slave : execute stage (receives *_i, drives *_o)
interface ex_muldiv_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 5
);
    logic [7:0]    aluop_i;
    logic [2:0]    alusel_i;
    logic [W-1:0]  reg1_i;
    logic [W-1:0]  reg2_i;
    logic [AW-1:0] waddr_i;
    logic          wreg_i;
    logic          flush_i;

    logic [AW-1:0] waddr_o;
    logic          wreg_o;
    logic [W-1:0]  wdata_o;
    logic [W-1:0]  reg2_o;
    logic          zero_o;
    logic          stall_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, waddr_i, wreg_i, flush_i,
        input  waddr_o, wreg_o, wdata_o, reg2_o, zero_o, stall_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, waddr_i, wreg_i, flush_i,
        output waddr_o, wreg_o, wdata_o, reg2_o, zero_o, stall_o
    );
endinterface

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative W-cycle multiply (shift-add) / divide (restoring).
//   clk, rst      clock, async active-low reset
//   aluop_i       op code; MULT/MULTU/DIV/DIVU start an operation from IDLE
//   a_i, b_i      operands (multiplicand/dividend, multiplier/divisor)
//   flush_i       abort, back to IDLE
//   hi_o, lo_o    sign-corrected result, meaningful while done_o=1
//   busy_o        in BUSY (iterating)
//   done_o        in DONE (result presented for one cycle)
module ex_muldiv_iter
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   aluop_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         flush_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o,
    output logic         busy_o,
    output logic         done_o
);
    localparam int unsigned   CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    md_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  hi_q, lo_q, opnd_q;
    logic          div_q, neg_q, a_neg_q, bz_q;

    logic          op_sgn, op_div, a_neg, b_neg;
    logic [W-1:0]  a_mag, b_mag;
    logic [W-1:0]  addend, div_diff, hi_d, lo_d;
    logic [W:0]    mul_sum, div_sh;
    logic          div_ge;
    logic [2*W-1:0] prod_neg;

    // Operand magnitudes and sign flags for signed ops
    assign op_sgn = (aluop_i == OP_MULT) || (aluop_i == OP_DIV);
    assign op_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign a_neg  = op_sgn && a_i[W-1];
    assign b_neg  = op_sgn && b_i[W-1];
    assign a_mag  = a_neg ? (~a_i + W'(1)) : a_i;
    assign b_mag  = b_neg ? (~b_i + W'(1)) : b_i;

    // One iteration. Multiply: {hi,lo} holds partial product over the
    // remaining multiplier bits. Divide: hi is the remainder, lo shifts the
    // dividend out and the quotient bits in. A zero divisor always "fits",
    // which yields an all-ones quotient and remainder = dividend.
    always_comb begin
        addend   = lo_q[0] ? opnd_q : '0;
        mul_sum  = {1'b0, hi_q} + {1'b0, addend};
        div_sh   = {hi_q, lo_q[W-1]};
        div_ge   = (div_sh >= {1'b0, opnd_q});
        div_diff = div_sh[W-1:0] - opnd_q;
        hi_d     = mul_sum[W:1];
        lo_d     = {mul_sum[0], lo_q[W-1:1]};
        if (div_q) begin
            hi_d = div_ge ? div_diff : div_sh[W-1:0];
            lo_d = {lo_q[W-2:0], div_ge};
        end
    end

    // Sign correction of the final magnitudes
    always_comb begin
        prod_neg = -{hi_q, lo_q};
        hi_o     = hi_q;
        lo_o     = lo_q;
        if (div_q) begin
            if (neg_q && !bz_q) lo_o = -lo_q;
            if (a_neg_q)        hi_o = -hi_q;
        end else if (neg_q) begin
            hi_o = prod_neg[2*W-1:W];
            lo_o = prod_neg[W-1:0];
        end
    end

    // FSM, counter and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            bz_q    <= 1'b0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_muldiv(aluop_i)) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= '0;
                        div_q   <= op_div;
                        neg_q   <= a_neg ^ b_neg;
                        a_neg_q <= a_neg;
                        bz_q    <= (b_i == '0);
                        hi_q    <= '0;
                        lo_q    <= op_div ? a_mag : b_mag;
                        opnd_q  <= op_div ? b_mag : a_mag;
                    end
                end
                ST_BUSY: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) state_q <= ST_DONE;
                end
                // Unconditional return so the op still in EX does not restart
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == ST_BUSY);
    assign done_o = (state_q == ST_DONE);

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: MIPS execute stage with combinational ALU and HI/LO registers.
//   clk, rst  clock, async active-low reset (all outputs 0 while low)
//   bus       ex_muldiv_if.slave: aluop/alusel/reg1/reg2/waddr/wreg/flush in;
//             waddr/wreg/wdata/reg2/zero/stall out
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned SW = $clog2(W)
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    logic [W-1:0]  hi_q, lo_q, hi_d, lo_d;
    logic [W-1:0]  md_hi, md_lo, alu_res, sra_res;
    logic [SW-1:0] shamt;
    logic          md_busy, md_done, md_idle, op_md, op_mt, stall_c;

    assign shamt   = bus.reg1_i[SW-1:0];
    assign sra_res = W'($signed(bus.reg2_i) >>> shamt);
    assign op_md   = is_muldiv(bus.aluop_i);
    assign op_mt   = (bus.aluop_i == OP_MTHI) || (bus.aluop_i == OP_MTLO);
    assign md_idle = !md_busy && !md_done;
    assign stall_c = !bus.flush_i && (md_busy || (md_idle && op_md));

    ex_muldiv_iter #(.W(W)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .aluop_i (bus.aluop_i),
        .a_i     (bus.reg1_i),
        .b_i     (bus.reg2_i),
        .flush_i (bus.flush_i),
        .hi_o    (md_hi),
        .lo_o    (md_lo),
        .busy_o  (md_busy),
        .done_o  (md_done)
    );

    // Single-cycle ALU and MOVE results
    always_comb begin
        alu_res = '0;
        case (bus.alusel_i)
            SEL_LOGIC: begin
                case (bus.aluop_i)
                    OP_OR:   alu_res = bus.reg1_i | bus.reg2_i;
                    OP_AND:  alu_res = bus.reg1_i & bus.reg2_i;
                    OP_XOR:  alu_res = bus.reg1_i ^ bus.reg2_i;
                    OP_NOR:  alu_res = ~(bus.reg1_i | bus.reg2_i);
                    default: alu_res = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (bus.aluop_i)
                    OP_SLL:  alu_res = bus.reg2_i << shamt;
                    OP_SRL:  alu_res = bus.reg2_i >> shamt;
                    OP_SRA:  alu_res = sra_res;
                    default: alu_res = '0;
                endcase
            end
            SEL_ARITH: begin
                case (bus.aluop_i)
                    OP_ADD:  alu_res = bus.reg1_i + bus.reg2_i;
                    OP_SUB:  alu_res = bus.reg1_i - bus.reg2_i;
                    OP_SLT:  alu_res = W'($signed(bus.reg1_i) < $signed(bus.reg2_i));
                    OP_SLTU: alu_res = W'(bus.reg1_i < bus.reg2_i);
                    default: alu_res = '0;
                endcase
            end
            SEL_MOVE: begin
                case (bus.aluop_i)
                    OP_MFHI: alu_res = hi_q;
                    OP_MFLO: alu_res = lo_q;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // HI/LO update: finished mul/div result, or MTHI/MTLO when not stalled
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!bus.flush_i) begin
            if (md_done) begin
                hi_d = md_hi;
                lo_d = md_lo;
            end else if (!stall_c) begin
                if (bus.aluop_i == OP_MTHI) hi_d = bus.reg1_i;
                if (bus.aluop_i == OP_MTLO) lo_d = bus.reg1_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Output muxing; everything held at 0 while in reset
    always_comb begin
        bus.waddr_o = AW'(0);
        bus.wreg_o  = 1'b0;
        bus.wdata_o = '0;
        bus.reg2_o  = '0;
        bus.zero_o  = 1'b0;
        bus.stall_o = 1'b0;
        if (rst) begin
            bus.waddr_o = bus.waddr_i;
            bus.wreg_o  = bus.wreg_i && !op_md && !op_mt;
            bus.wdata_o = alu_res;
            bus.reg2_o  = bus.reg2_i;
            bus.zero_o  = ((bus.alusel_i == SEL_LOGIC) || (bus.alusel_i == SEL_SHIFT) ||
                           (bus.alusel_i == SEL_ARITH)) && (alu_res == '0);
            bus.stall_o = stall_c;
        end
    end

endmodule
